// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches to
// instruction memory and presents returned words to decode through a small
// in-order queue. When the queue is empty, a returning word bypasses straight
// to the IF/ID outputs so a 1-cycle memory sustains one instruction per cycle.
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_id_valid,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    // Spare top bit keeps the credit sum from wrapping before the compare
    localparam int CW = $clog2(QUEUE_DEPTH + 1) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    localparam logic [31:0]   NOP     = 32'h00000013;

    // Branch targets are forced onto a word boundary
    function automatic logic [63:0] align_pc(input logic [63:0] target);
        return target & ~64'h3;
    endfunction

    logic [63:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] q_count;
    logic [PW-1:0] q_rd;
    logic [PW-1:0] q_wr;
    logic [PW-1:0] t_rd;
    logic [PW-1:0] t_wr;

    logic [63:0] q_pc    [QUEUE_DEPTH];
    logic [31:0] q_instr [QUEUE_DEPTH];
    logic [63:0] t_addr  [QUEUE_DEPTH];

    logic          q_empty;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_take;
    logic          deq;
    logic          deq_q;
    logic          enq_q;
    logic [63:0]   resp_tag;
    logic [CW-1:0] in_flight;

    assign q_empty   = (q_count == '0);
    assign req_fire  = imem_req_valid && imem_req_ready;
    // Wrong-path responses always precede right-path ones, so drop is served first
    assign resp_drop = imem_resp_valid && (drop != '0);
    assign resp_take = imem_resp_valid && (drop == '0) && (outstanding != '0);
    assign resp_tag  = t_addr[t_rd];

    // Credit depends on registered state only, never on stall or redirect
    assign in_flight      = outstanding + drop + q_count;
    assign imem_req_valid = (in_flight < DEPTH_C);
    assign imem_req_addr  = pc;

    assign deq   = if_id_valid && !stall;
    assign deq_q = deq && !q_empty;
    // A bypassed word consumed in its arrival cycle never enters storage
    assign enq_q = resp_take && !(q_empty && !stall);

    // IF/ID view: queue head, else the arriving word, else a NOP bubble
    always_comb begin
        if_id_valid       = 1'b0;
        if_id_pc          = '0;
        if_id_instruction = NOP;
        if (!q_empty) begin
            if_id_valid       = 1'b1;
            if_id_pc          = q_pc[q_rd];
            if_id_instruction = q_instr[q_rd];
        end else if (resp_take) begin
            if_id_valid       = 1'b1;
            if_id_pc          = resp_tag;
            if_id_instruction = imem_resp_data;
        end
    end

    // Control state: PC, credit counters and queue/tag pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            q_count     <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
        end else if (redirect_valid) begin
            // Everything in flight, including this cycle's request, becomes wrong-path
            pc          <= align_pc(redirect_pc);
            drop        <= drop + outstanding + CW'(req_fire) - CW'(resp_drop || resp_take);
            outstanding <= '0;
            q_count     <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            t_rd        <= '0;
            t_wr        <= '0;
        end else begin
            if (req_fire) begin
                pc   <= pc + 64'd4;
                t_wr <= t_wr + PW'(1);
            end
            if (resp_take) begin
                t_rd <= t_rd + PW'(1);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_take);
            drop        <= drop - CW'(resp_drop);
            if (enq_q) begin
                q_wr <= q_wr + PW'(1);
            end
            if (deq_q) begin
                q_rd <= q_rd + PW'(1);
            end
            q_count <= q_count + CW'(enq_q) - CW'(deq_q);
        end
    end

    // Payload storage: issued-address tags and returned words, qualified by pointers
    always_ff @(posedge clk) begin
        if (req_fire) begin
            t_addr[t_wr] <= pc;
        end
        if (enq_q) begin
            q_pc[q_wr]    <= resp_tag;
            q_instr[q_wr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed scenarios plus a randomized
// run against a queue-based reference of the fetch stream and memory.
module tb_instruction_fetch_stage;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          QD       = 2;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] SALT     = 32'hA5A50000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;

    always #5 clk = ~clk;

    instruction_fetch_stage #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction)
    );

    // In-flight fetch held by the memory; 'wrong' marks a squashed path
    typedef struct {
        logic [63:0] pc;
        logic [63:0] addr;
        int          due;
        logic        wrong;
    } flight_t;

    // Returned right-path word not yet taken by decode
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    flight_t     mem_q[$];
    entry_t      ret_q[$];
    logic [63:0] m_pc;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    int          n_checks;
    int          n_pass;
    logic [63:0] got[$];

    logic        obs_req_valid, obs_valid;
    logic [63:0] obs_addr, obs_pc;
    logic [31:0] obs_instr;
    logic        exp_req_valid, exp_valid;
    logic [63:0] exp_addr, exp_pc;
    logic [31:0] exp_instr;
    int          exp_in_flight;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ SALT;
    endfunction

    task automatic drive_mem();
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_of(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    // One clock: sample outputs, predict, advance the reference, drive memory
    task automatic cycle();
        flight_t f;
        entry_t  e;
        logic    hs;
        @(negedge clk);
        obs_req_valid = imem_req_valid;
        obs_addr      = imem_req_addr;
        obs_valid     = if_id_valid;
        obs_pc        = if_id_pc;
        obs_instr     = if_id_instruction;
        exp_in_flight = mem_q.size() + ret_q.size();
        exp_req_valid = (exp_in_flight < QD);
        exp_addr      = m_pc;
        exp_valid     = 1'b0;
        exp_pc        = '0;
        exp_instr     = NOP;
        if (ret_q.size() > 0) begin
            exp_valid = 1'b1;
            exp_pc    = ret_q[0].pc;
            exp_instr = ret_q[0].instr;
        end else if (imem_resp_valid && !mem_q[0].wrong) begin
            exp_valid = 1'b1;
            exp_pc    = mem_q[0].pc;
            exp_instr = word_of(mem_q[0].pc);
        end
        hs = imem_req_valid && imem_req_ready;
        if (imem_resp_valid) begin
            f = mem_q.pop_front();
            if (!f.wrong) begin
                e.pc    = f.pc;
                e.instr = word_of(f.pc);
                ret_q.push_back(e);
            end
        end
        if (redirect_valid) begin
            ret_q.delete();
            foreach (mem_q[i]) mem_q[i].wrong = 1'b1;
        end else if (!stall && ret_q.size() > 0) begin
            void'(ret_q.pop_front());
        end
        if (hs) begin
            f.pc    = m_pc;
            f.addr  = imem_req_addr;
            f.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
            f.wrong = redirect_valid;
            mem_q.push_back(f);
        end
        if (redirect_valid) m_pc = redirect_pc & ~64'h3;
        else if (hs)        m_pc = m_pc + 64'd4;
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic idle_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        mem_q.delete();
        ret_q.delete();
        m_pc            = RESET_PC;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        lat_lo          = 1;
        lat_hi          = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        drive_mem();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", if_id_valid); else n_pass++;
        n_checks++; if (if_id_pc !== 64'h0) $display("FAIL reset_pc: got %h expected 0", if_id_pc); else n_pass++;
        n_checks++; if (if_id_instruction !== NOP) $display("FAIL reset_instr: got %h expected %h", if_id_instruction, NOP); else n_pass++;
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL reset_req_valid: got %b expected 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== RESET_PC) $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC); else n_pass++;
        do_reset();
        cycle();
        n_checks++; if (obs_req_valid !== 1'b1) $display("FAIL reset_first_req: got %b expected 1", obs_req_valid); else n_pass++;
        n_checks++; if (obs_addr !== RESET_PC) $display("FAIL reset_first_addr: got %h expected %h", obs_addr, RESET_PC); else n_pass++;
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL reset_first_valid: got %b expected 0", obs_valid); else n_pass++;
    endtask

    task automatic test_stream();
        logic [63:0] want;
        do_reset();
        for (int j = 0; j < 12; j++) begin
            cycle();
            n_checks++; if (obs_addr !== RESET_PC + 64'(4 * j)) $display("FAIL stream_addr[%0d]: got %h expected %h", j, obs_addr, RESET_PC + 64'(4 * j)); else n_pass++;
            n_checks++; if (obs_req_valid !== 1'b1) $display("FAIL stream_req_valid[%0d]: got %b expected 1", j, obs_req_valid); else n_pass++;
            if (j == 0) begin
                n_checks++; if (obs_valid !== 1'b0) $display("FAIL stream_valid[0]: got %b expected 0", obs_valid); else n_pass++;
            end else begin
                want = RESET_PC + 64'(4 * (j - 1));
                n_checks++; if ({obs_valid, obs_pc} !== {1'b1, want}) $display("FAIL stream_pc[%0d]: got %b/%h expected 1/%h", j, obs_valid, obs_pc, want); else n_pass++;
                n_checks++; if (obs_instr !== word_of(want)) $display("FAIL stream_instr[%0d]: got %h expected %h", j, obs_instr, word_of(want)); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] want;
        do_reset();
        for (int j = 0; j < 10; j++) begin
            stall = (j >= 3 && j <= 5);
            cycle();
            if (j >= 3 && j <= 5) begin
                n_checks++; if ({obs_valid, obs_pc} !== {1'b1, 64'h8}) $display("FAIL stall_hold[%0d]: got %b/%h expected 1/8", j, obs_valid, obs_pc); else n_pass++;
            end
            if (j == 4 || j == 5) begin
                n_checks++; if (obs_req_valid !== 1'b0) $display("FAIL stall_credit[%0d]: got %b expected 0", j, obs_req_valid); else n_pass++;
            end
            if (j >= 6) begin
                want = 64'h8 + 64'(4 * (j - 6));
                n_checks++; if ({obs_valid, obs_pc} !== {1'b1, want}) $display("FAIL stall_release[%0d]: got %b/%h expected 1/%h", j, obs_valid, obs_pc, want); else n_pass++;
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_latency();
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        got.delete();
        for (int j = 0; j < 15; j++) begin
            redirect_valid = (j == 2);
            redirect_pc    = 64'h100;
            cycle();
            if (j == 3 || j == 4) begin
                n_checks++; if (obs_valid !== 1'b0) $display("FAIL redir_drop_valid[%0d]: got %b expected 0", j, obs_valid); else n_pass++;
            end
            if (j >= 3 && obs_valid) got.push_back(obs_pc);
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (got.size() < 2) $display("FAIL redir_stream_len: got %0d expected at least 2", got.size());
        else begin
            n_pass++;
            n_checks++; if (got[0] !== 64'h100) $display("FAIL redir_first_pc: got %h expected 100", got[0]); else n_pass++;
            n_checks++; if (got[1] !== 64'h104) $display("FAIL redir_second_pc: got %h expected 104", got[1]); else n_pass++;
        end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        for (int j = 0; j < 6; j++) begin
            redirect_valid = (j == 1);
            redirect_pc    = 64'h203;
            cycle();
            if (j == 1) begin
                n_checks++; if ({obs_req_valid, obs_addr} !== {1'b1, 64'h4}) $display("FAIL same_hs: got %b/%h expected 1/4", obs_req_valid, obs_addr); else n_pass++;
            end
            if (j == 2) begin
                n_checks++; if (obs_valid !== 1'b0) $display("FAIL same_flush_valid: got %b expected 0", obs_valid); else n_pass++;
                n_checks++; if ({obs_req_valid, obs_addr} !== {1'b1, 64'h200}) $display("FAIL same_req_addr: got %b/%h expected 1/200", obs_req_valid, obs_addr); else n_pass++;
            end
            if (j == 3) begin
                n_checks++; if ({obs_valid, obs_pc} !== {1'b1, 64'h200}) $display("FAIL same_first_pc: got %b/%h expected 1/200", obs_valid, obs_pc); else n_pass++;
            end
            if (j == 4) begin
                n_checks++; if ({obs_valid, obs_pc} !== {1'b1, 64'h204}) $display("FAIL same_second_pc: got %b/%h expected 1/204", obs_valid, obs_pc); else n_pass++;
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        stall = 1'b1;
        repeat (5) cycle();
        n_checks++; if ({obs_valid, obs_pc, obs_req_valid} !== {1'b1, 64'h0, 1'b0}) $display("FAIL mid_full: got %b/%h/%b expected 1/0/0", obs_valid, obs_pc, obs_req_valid); else n_pass++;
        rst = 1'b1;
        mem_q.delete();
        ret_q.delete();
        imem_resp_valid = 1'b0;
        #1;
        n_checks++; if (if_id_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", if_id_valid); else n_pass++;
        n_checks++; if (if_id_instruction !== NOP) $display("FAIL mid_reset_instr: got %h expected %h", if_id_instruction, NOP); else n_pass++;
        n_checks++; if (if_id_pc !== 64'h0) $display("FAIL mid_reset_pc: got %h expected 0", if_id_pc); else n_pass++;
        n_checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RESET_PC}) $display("FAIL mid_reset_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RESET_PC); else n_pass++;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stall = 1'b0;
        m_pc  = RESET_PC;
        cyc   = 0;
        drive_mem();
        cycle();
        n_checks++; if ({obs_req_valid, obs_addr} !== {1'b1, RESET_PC}) $display("FAIL mid_release_req: got %b/%h expected 1/%h", obs_req_valid, obs_addr, RESET_PC); else n_pass++;
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL mid_release_valid: got %b expected 0", obs_valid); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        got.delete();
        for (int j = 0; j < 12; j++) begin
            redirect_valid = (j == 0);
            redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF9;
            cycle();
            if (j >= 1 && obs_valid) got.push_back(obs_pc);
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (got.size() < 4) $display("FAIL wrap_stream_len: got %0d expected at least 4", got.size());
        else begin
            n_pass++;
            n_checks++; if (got[0] !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL wrap_pc0: got %h expected fffffffffffffff8", got[0]); else n_pass++;
            n_checks++; if (got[1] !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc1: got %h expected fffffffffffffffc", got[1]); else n_pass++;
            n_checks++; if (got[2] !== 64'h0) $display("FAIL wrap_pc2: got %h expected 0", got[2]); else n_pass++;
            n_checks++; if (got[3] !== 64'h4) $display("FAIL wrap_pc3: got %h expected 4", got[3]); else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_lo = 1;
        lat_hi = 4;
        for (int j = 0; j < 1000; j++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            stall          = ($urandom_range(3, 0) == 0);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc    = {$urandom, $urandom};
            cycle();
            n_checks++; if (obs_req_valid !== exp_req_valid) $display("FAIL rand_req_valid[%0d]: got %b expected %b", j, obs_req_valid, exp_req_valid); else n_pass++;
            n_checks++; if (obs_addr !== exp_addr) $display("FAIL rand_addr[%0d]: got %h expected %h", j, obs_addr, exp_addr); else n_pass++;
            n_checks++; if (obs_valid !== exp_valid) $display("FAIL rand_valid[%0d]: got %b expected %b", j, obs_valid, exp_valid); else n_pass++;
            n_checks++; if (obs_pc !== exp_pc) $display("FAIL rand_pc[%0d]: got %h expected %h", j, obs_pc, exp_pc); else n_pass++;
            n_checks++; if (obs_instr !== exp_instr) $display("FAIL rand_instr[%0d]: got %h expected %h", j, obs_instr, exp_instr); else n_pass++;
            n_checks++; if (exp_in_flight > QD) $display("FAIL rand_credit[%0d]: in flight %0d limit %0d", j, exp_in_flight, QD); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        lat_lo   = 1;
        lat_hi   = 1;
        m_pc     = RESET_PC;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_same_cycle();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d of %0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- Front end of the 5-stage pipeline; produces the instruction stream that the decode stage consumes.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel with a latency-tolerant response channel.
- Buffers returned words in a small in-order queue whose head drives the IF/ID outputs.
- Honours decode-stage stalls and branch redirects; discards in-flight wrong-path responses.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- QUEUE_DEPTH, 2, instruction queue entries; also the maximum number of outstanding fetches (power of two, ≥2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  64  fetch address, equal to the current PC.
- imem_resp_valid  input  1  fetched word returned this cycle; responses arrive in request order.
- imem_resp_data  input  32  fetched instruction word.
- stall  input  1  decode hazard; holds the IF/ID outputs.
- redirect_valid  input  1  taken branch or jump resolved downstream.
- redirect_pc  input  64  branch target.
- if_id_valid  output  1  IF/ID holds a valid instruction.
- if_id_pc  output  64  PC of the IF/ID instruction.
- if_id_instruction  output  32  instruction to decode.

Behaviour:
- Reset, asynchronous: pc=RESET_PC; queue empty; outstanding=0; drop=0. Outputs during and after reset: imem_req_valid=1 (credit is available), imem_req_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instruction=32'h00000013 (NOP).
- Reset mid-operation aborts all state immediately. Responses arriving after reset release for requests issued before reset are outside the contract; the memory is reset together with this block.
- Credit: imem_req_valid = (outstanding + drop + occupancy) < QUEUE_DEPTH. It is purely a function of registered state and never depends on redirect_valid or stall.
- Request handshake (imem_req_valid && imem_req_ready): pc <= pc+4 (64-bit wrap at 2^64); outstanding increments.
- Response:
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise: {pc_tag, data} is enqueued and outstanding decrements.
  - pc_tag comes from a per-outstanding FIFO of issued addresses of depth QUEUE_DEPTH.
  - A response with outstanding=0 and drop=0 is ignored and must not corrupt any counter.
- Output: show-ahead. if_id_* mirror the queue head combinationally from registers. With an empty queue: if_id_valid=0, if_id_pc=0, if_id_instruction=NOP.
- Dequeue: when if_id_valid && !stall. With stall=1, the head holds stable.
- Latency: for a 1-cycle memory, the address accepted at cycle N appears on if_id at cycle N+1 (response at N+1, same-cycle enqueue bypass to head when the queue is empty). Same-cycle enqueue and dequeue are permitted at full occupancy.
- Redirect (redirect_valid=1), which has priority over every other event in the same cycle:
  - The queue is flushed (including any same-cycle enqueue); if_id_valid=0 next cycle.
  - drop <= drop + outstanding + (request handshaked this cycle) − (response consumed this cycle).
  - outstanding <= 0; the tag FIFO is cleared.
  - pc <= {redirect_pc[63:2], 2'b00}. Misaligned targets are silently aligned.
  - A request handshaked in the redirect cycle is wrong-path, and its response is dropped.
  - stall is ignored in the redirect cycle.
- Back-to-back redirects accumulate drop correctly; drop never exceeds QUEUE_DEPTH.
- Invariant: outstanding + drop + occupancy ≤ QUEUE_DEPTH at all times. The bench asserts it every cycle.

Test Plan:
- Reset, then 1-cycle memory (ready=1, response next cycle, word = addr ^ 32'hA5A50000), stall=0 -> if_id_pc sequence 0x0, 0x4, 0x8, … one per cycle from cycle 2; if_id_valid=1 continuous.
- stall=1 for 3 cycles while the head has pc=0x8 -> if_id_pc stays 0x8; imem_req_valid drops to 0 once credit is used (occupancy=2); after release, 0xC follows with no gaps or duplicates.
- 3-cycle response latency, redirect_valid=1 with redirect_pc=0x100 while 2 requests are outstanding -> both responses dropped; next if_id_pc=0x100, then 0x104.
- redirect_pc=0x203 in the same cycle as a request handshake and a response -> request and response both discarded; next imem_req_addr=0x200.
- Assert rst mid-stream with 2 entries queued -> immediate if_id_valid=0, if_id_instruction=0x00000013; after release, imem_req_addr=RESET_PC.
- imem_req_ready toggled randomly, latency 1–4, 1000 cycles with random stall and redirect -> if_id_pc stream matches a reference PC model, and the credit invariant is never violated.
